// File: rtl/mov_reg_bank_pkg.sv
// mov_reg_bank_pkg
//   Definitions shared by the MOV register bank:
//   - DW       : default data width of registers and data ports
//   - state_t  : FSM state encoding (IDLE, READ, WRITE)
//   - SEL_R0..SEL_R6, SEL_MEM : 3-bit source/destination selector codes
package mov_reg_bank_pkg;

  localparam int unsigned DW = 8;

  localparam int unsigned NUM_REGS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [2:0] SEL_R0  = 3'd0;
  localparam logic [2:0] SEL_R1  = 3'd1;
  localparam logic [2:0] SEL_R2  = 3'd2;
  localparam logic [2:0] SEL_R3  = 3'd3;
  localparam logic [2:0] SEL_R4  = 3'd4;
  localparam logic [2:0] SEL_R5  = 3'd5;
  localparam logic [2:0] SEL_R6  = 3'd6;
  localparam logic [2:0] SEL_MEM = 3'd7;

  // True when a selector addresses one of the registers rather than memory.
  function automatic logic is_reg_sel(input logic [2:0] sel);
    return sel != SEL_MEM;
  endfunction

endpackage

// File: rtl/mov_reg_bank_src_select.sv
// src_select
//   Purely combinational 8:1 source selector for the MOV register bank.
//   Ports:
//     sel       : source select, SEL_R0..SEL_R6 pick R0-R6, SEL_MEM picks mem
//     r0 .. r6  : current register contents
//     mem       : memory read data
//     data      : selected source value
module src_select
  import mov_reg_bank_pkg::*;
#(
  parameter int unsigned DW = mov_reg_bank_pkg::DW
) (
  input  logic [2:0]    sel,
  input  logic [DW-1:0] r0,
  input  logic [DW-1:0] r1,
  input  logic [DW-1:0] r2,
  input  logic [DW-1:0] r3,
  input  logic [DW-1:0] r4,
  input  logic [DW-1:0] r5,
  input  logic [DW-1:0] r6,
  input  logic [DW-1:0] mem,
  output logic [DW-1:0] data
);

  always_comb begin
    data = '0;
    unique case (sel)
      SEL_R0:  data = r0;
      SEL_R1:  data = r1;
      SEL_R2:  data = r2;
      SEL_R3:  data = r3;
      SEL_R4:  data = r4;
      SEL_R5:  data = r5;
      SEL_R6:  data = r6;
      SEL_MEM: data = mem;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mov_reg_bank.sv
// mov_reg_bank
//   Seven-register bank executing "MOV Rx,Ry" commands through a three-state
//   FSM (IDLE -> READ -> WRITE -> IDLE), plus an immediate load port that can
//   write any register in any state.
//
//   Ports:
//     clk, nrst           : clock (rising edge), asynchronous active-low reset
//     cmd_valid/cmd_ready : command handshake; ready only in IDLE
//     cmd_src             : source select (0-6 = R0-R6, 7 = MEMCEE)
//     cmd_dst             : destination select (0-6 = R0-R6, 7 = memory write)
//     MEMCEE              : memory read data
//     ld_en/ld_sel/ld_data: immediate load; ld_sel = 7 is ignored
//     R0 .. R6            : register contents
//     mem_we/mem_wdata    : memory write strobe/data, valid in the done cycle
//     done                : one-cycle pulse after a move completes
//     zflag               : (MOV_FLAGS_EN only) moved value was zero
//
//   Optional feature: define MOV_FLAGS_EN to add the zflag output.
module mov_reg_bank
  import mov_reg_bank_pkg::*;
#(
  parameter int unsigned         DW      = mov_reg_bank_pkg::DW,
  parameter logic [DW-1:0]       RST_VAL = '0
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_src,
  input  logic [2:0]    cmd_dst,
  input  logic [DW-1:0] MEMCEE,
  input  logic          ld_en,
  input  logic [2:0]    ld_sel,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] R0,
  output logic [DW-1:0] R1,
  output logic [DW-1:0] R2,
  output logic [DW-1:0] R3,
  output logic [DW-1:0] R4,
  output logic [DW-1:0] R5,
  output logic [DW-1:0] R6,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          done
`ifdef MOV_FLAGS_EN
  ,
  output logic          zflag
`endif
);

  state_t        state;
  state_t        state_nxt;

  logic [2:0]    src_q;
  logic [2:0]    dst_q;
  logic [DW-1:0] hold;
  logic [DW-1:0] src_data;
  logic [DW-1:0] regs [NUM_REGS];

  logic          accept;
  logic          write_edge;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    write_edge = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) begin
          state_nxt = READ;
        end
      end
      READ: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        write_edge = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch and hold register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      src_q <= SEL_R0;
      dst_q <= SEL_R0;
    end else if (accept) begin
      src_q <= cmd_src;
      dst_q <= cmd_dst;
    end
  end

  src_select #(
    .DW (DW)
  ) u_src_select (
    .sel  (src_q),
    .r0   (regs[0]),
    .r1   (regs[1]),
    .r2   (regs[2]),
    .r3   (regs[3]),
    .r4   (regs[4]),
    .r5   (regs[5]),
    .r6   (regs[6]),
    .mem  (MEMCEE),
    .data (src_data)
  );

  // The selector sees the pre-edge register values, so an immediate load to
  // the source register on the READ edge cannot leak into the hold value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold <= '0;
    end else if (state == READ) begin
      hold <= src_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: the move takes priority over an immediate load to the same
  // register; loads to other registers proceed in parallel.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RST_VAL;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (write_edge && (dst_q == 3'(i))) begin
          regs[i] <= hold;
        end else if (ld_en && is_reg_sel(ld_sel) && (ld_sel == 3'(i))) begin
          regs[i] <= ld_data;
        end
      end
    end
  end

  assign R0 = regs[0];
  assign R1 = regs[1];
  assign R2 = regs[2];
  assign R3 = regs[3];
  assign R4 = regs[4];
  assign R5 = regs[5];
  assign R6 = regs[6];

  // ---------------------------------------------------------------------------
  // Completion and memory write: both registered at the WRITE edge so they are
  // visible together for the single cycle that follows.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      done   <= write_edge;
      mem_we <= write_edge && !is_reg_sel(dst_q);
      if (write_edge && !is_reg_sel(dst_q)) begin
        mem_wdata <= hold;
      end
    end
  end

`ifdef MOV_FLAGS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      zflag <= 1'b0;
    end else if (write_edge) begin
      zflag <= (hold == '0);
    end
  end
`endif

endmodule

// File: tb/tb_mov_reg_bank.sv
module tb_mov_reg_bank;

  logic       clk = 1'b0;
  logic       nrst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_src;
  logic [2:0] cmd_dst;
  logic [7:0] memcee;
  logic       ld_en;
  logic [2:0] ld_sel;
  logic [7:0] ld_data;
  logic [7:0] r0, r1, r2, r3, r4, r5, r6;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       done;
`ifdef MOV_FLAGS_EN
  logic       zflag;
`endif

  logic [7:0] rv [7];
  logic [7:0] expr [7];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mov_reg_bank #(
    .DW      (8),
    .RST_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .MEMCEE    (memcee),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .ld_data   (ld_data),
    .R0        (r0),
    .R1        (r1),
    .R2        (r2),
    .R3        (r3),
    .R4        (r4),
    .R5        (r5),
    .R6        (r6),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .done      (done)
`ifdef MOV_FLAGS_EN
    ,
    .zflag     (zflag)
`endif
  );

  assign rv[0] = r0;
  assign rv[1] = r1;
  assign rv[2] = r2;
  assign rv[3] = r3;
  assign rv[4] = r4;
  assign rv[5] = r5;
  assign rv[6] = r6;

  // Advance one edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ld(input logic [2:0] sel, input logic [7:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  // Presents a command for one edge (accepted from IDLE).
  task automatic issue(input logic [2:0] src, input logic [2:0] dst);
    cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0;
    memcee = '0; ld_en = 1'b0; ld_sel = '0; ld_data = '0;
    #12;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (rv[i] !== 8'h00) begin
        miscompares++; $display("FAIL reset_R%0d: got %h exp 00", i, rv[i]);
      end
    end
    nrst = 1'b1;
    tick();
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b exp 1", cmd_ready); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b exp 0", done); end
    vectors++;
    if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b exp 0", mem_we); end
    vectors++;
    if (mem_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_mem_wdata: got %h exp 00", mem_wdata); end
`ifdef MOV_FLAGS_EN
    vectors++;
    if (zflag !== 1'b0) begin miscompares++; $display("FAIL reset_zflag: got %b exp 0", zflag); end
`endif
  endtask

  task automatic test_move_latency();
    do_ld(3'd2, 8'h5A);
    vectors++;
    if (r2 !== 8'h5A) begin miscompares++; $display("FAIL ld_R2: got %h exp 5a", r2); end
    issue(3'd2, 3'd5);                               // edge 1: accept
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL read_ready: got %b exp 0", cmd_ready); end
    vectors++;
    if (r5 !== 8'h00) begin miscompares++; $display("FAIL lat_e1_R5: got %h exp 00", r5); end
    tick();                                          // edge 2: capture
    vectors++;
    if (r5 !== 8'h00 || done !== 1'b0) begin
      miscompares++; $display("FAIL lat_e2: got R5=%h done=%b exp R5=00 done=0", r5, done);
    end
    tick();                                          // edge 3: write
    vectors++;
    if (r5 !== 8'h5A) begin miscompares++; $display("FAIL lat_e3_R5: got %h exp 5a", r5); end
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL lat_done: got %b exp 1", done); end
    vectors++;
    if (mem_we !== 1'b0) begin miscompares++; $display("FAIL lat_mem_we: got %b exp 0", mem_we); end
    tick();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL done_width: got %b exp 0", done); end
  endtask

  task automatic test_memory();
    memcee = 8'hC3;
    issue(3'd7, 3'd0);
    tick(); tick();
    vectors++;
    if (r0 !== 8'hC3) begin miscompares++; $display("FAIL mem_rd_R0: got %h exp c3", r0); end
    memcee = 8'h00;
    tick();
    do_ld(3'd4, 8'h11);
    issue(3'd4, 3'd7);
    tick(); tick();
    vectors++;
    if (mem_we !== 1'b1) begin miscompares++; $display("FAIL mem_we: got %b exp 1", mem_we); end
    vectors++;
    if (mem_wdata !== 8'h11) begin miscompares++; $display("FAIL mem_wdata: got %h exp 11", mem_wdata); end
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL mem_done: got %b exp 1", done); end
    expr[0] = 8'hC3; expr[1] = 8'h00; expr[2] = 8'h5A; expr[3] = 8'h00;
    expr[4] = 8'h11; expr[5] = 8'h5A; expr[6] = 8'h00;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (rv[i] !== expr[i]) begin
        miscompares++; $display("FAIL mem_wr_R%0d: got %h exp %h", i, rv[i], expr[i]);
      end
    end
    tick();
    vectors++;
    if (mem_we !== 1'b0) begin miscompares++; $display("FAIL mem_we_width: got %b exp 0", mem_we); end
  endtask

  task automatic test_ld_collision();
    do_ld(3'd6, 8'h22);
    issue(3'd6, 3'd3);
    tick();
    ld_en = 1'b1; ld_sel = 3'd3; ld_data = 8'hFF;    // same edge, same target
    tick();
    ld_en = 1'b0;
    vectors++;
    if (r3 !== 8'h22) begin miscompares++; $display("FAIL coll_same_R3: got %h exp 22", r3); end
    do_ld(3'd3, 8'h00);
    issue(3'd6, 3'd3);
    tick();
    ld_en = 1'b1; ld_sel = 3'd1; ld_data = 8'hFF;    // same edge, other target
    tick();
    ld_en = 1'b0;
    vectors++;
    if (r3 !== 8'h22) begin miscompares++; $display("FAIL coll_diff_R3: got %h exp 22", r3); end
    vectors++;
    if (r1 !== 8'hFF) begin miscompares++; $display("FAIL coll_diff_R1: got %h exp ff", r1); end
    do_ld(3'd7, 8'h99);                              // ignored selector
    vectors++;
    if (r0 !== 8'hC3 || r6 !== 8'h22) begin
      miscompares++; $display("FAIL ld_sel7: got R0=%h R6=%h exp c3 22", r0, r6);
    end
  endtask

  task automatic test_ld_during_read();
    issue(3'd6, 3'd2);                               // R6 = 22
    ld_en = 1'b1; ld_sel = 3'd6; ld_data = 8'h77;    // load on the capture edge
    tick();
    ld_en = 1'b0;
    vectors++;
    if (r6 !== 8'h77) begin miscompares++; $display("FAIL rd_ld_R6: got %h exp 77", r6); end
    tick();
    vectors++;
    if (r2 !== 8'h22) begin miscompares++; $display("FAIL rd_ld_hold: got %h exp 22", r2); end
    tick();
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_src = 3'd0; cmd_dst = 3'd2;   // R2 <= C3
    tick();
    cmd_src = 3'd1; cmd_dst = 3'd4;                     // held high during READ
    tick();
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_write_ready: got %b exp 0", cmd_ready); end
    tick();
    vectors++;
    if (r2 !== 8'hC3 || done !== 1'b1 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got R2=%h done=%b rdy=%b exp c3 1 1", r2, done, cmd_ready);
    end
    vectors++;
    if (r4 !== 8'h11) begin miscompares++; $display("FAIL b2b_no_early: got R4=%h exp 11", r4); end
    tick();                                             // second accepted in done cycle
    cmd_valid = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL b2b_accept: got rdy=%b done=%b exp 0 0", cmd_ready, done);
    end
    tick(); tick();
    vectors++;
    if (r4 !== 8'hFF || done !== 1'b1) begin
      miscompares++; $display("FAIL b2b_second: got R4=%h done=%b exp ff 1", r4, done);
    end
    // Valid raised only during READ/WRITE must not be queued.
    tick();
    issue(3'd0, 3'd6);                                  // R6 <= C3
    cmd_valid = 1'b1; cmd_src = 3'd5; cmd_dst = 3'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    vectors++;
    if (r6 !== 8'hC3) begin miscompares++; $display("FAIL ign_move: got R6=%h exp c3", r6); end
    tick(); tick(); tick();
    vectors++;
    if (r3 !== 8'h22 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ign_queue: got R3=%h done=%b rdy=%b exp 22 0 1", r3, done, cmd_ready);
    end
  endtask

  task automatic test_reset_abort();
    issue(3'd5, 3'd0);                                  // now in READ
    #2 nrst = 1'b0;
    #2;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (rv[i] !== 8'h00) begin
        miscompares++; $display("FAIL abort_R%0d: got %h exp 00", i, rv[i]);
      end
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b exp 1", cmd_ready); end
    nrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || mem_we !== 1'b0 || r0 !== 8'h00) begin
        miscompares++;
        $display("FAIL abort_post%0d: got done=%b we=%b R0=%h exp 0 0 00", k, done, mem_we, r0);
      end
    end
`ifdef MOV_FLAGS_EN
    do_ld(3'd1, 8'h40);
    issue(3'd1, 3'd2);
    tick(); tick();
    vectors++;
    if (zflag !== 1'b0) begin miscompares++; $display("FAIL zflag_nz: got %b exp 0", zflag); end
    issue(3'd3, 3'd4);                                  // moves 00
    tick(); tick();
    vectors++;
    if (zflag !== 1'b1) begin miscompares++; $display("FAIL zflag_z: got %b exp 1", zflag); end
    tick();
    vectors++;
    if (zflag !== 1'b1) begin miscompares++; $display("FAIL zflag_hold: got %b exp 1", zflag); end
`endif
  endtask

  initial begin
    test_reset();
    test_move_latency();
    test_memory();
    test_ld_collision();
    test_ld_during_read();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mov_reg_bank.md
MOV_REG_BANK -- requirements
Module: mov_reg_bank

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the data width of every register and data port.
REQ-002 The block SHALL have parameter RST_VAL, default 8'h00, giving the reset value of R0-R6.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port nrst, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: a MOV Rx,Ry request is present.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port cmd_src, input, 3 bits: source select, 0-6 = R0-R6, 7 = MEMCEE.
REQ-008 The block SHALL have port cmd_dst, input, 3 bits: destination select, 0-6 = R0-R6, 7 = memory write.
REQ-009 The block SHALL have port MEMCEE, input, DW bits: memory read data.
REQ-010 The block SHALL have ports ld_en (1 bit), ld_sel (3 bits) and ld_data (DW bits), all inputs: direct immediate load port.
REQ-011 The block SHALL have ports R0-R6, outputs, DW bits each: current register contents.
REQ-012 The block SHALL have ports mem_we (output, 1 bit) and mem_wdata (output, DW bits): memory write strobe and write data.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a move completes.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, READ and WRITE.
REQ-015 cmd_ready SHALL be 1 only in IDLE.
REQ-016 A command SHALL be accepted at the edge where cmd_valid=1 and cmd_ready=1; at that edge cmd_src and cmd_dst SHALL be latched and the FSM SHALL go IDLE->READ.
REQ-017 In READ, the source selected by the latched cmd_src SHALL be captured into a DW-bit hold register at the next edge, and the FSM SHALL go READ->WRITE.
REQ-018 In WRITE, at the next edge, the hold value SHALL be written to the latched destination, done SHALL be set to 1 for exactly one cycle, and the FSM SHALL go WRITE->IDLE.
REQ-019 End-to-end latency SHALL be 3 edges from acceptance to the register update; the next command SHALL be accepted no earlier than the cycle in which done=1.
REQ-020 When dst=7, no register SHALL change; mem_we SHALL be 1 and mem_wdata SHALL equal the hold value for the single cycle in which done=1.
REQ-021 When src=dst, the register value SHALL be unchanged, and done SHALL still pulse.
REQ-022 When ld_en=1 and ld_sel<7, R[ld_sel] SHALL take ld_data at the edge in any state; ld_sel=7 SHALL be ignored.
REQ-023 When a WRITE-edge move and an ld write target the same register at the same edge, the move SHALL win; when they target different registers, both writes SHALL occur.
REQ-024 An ld write to the move's source register during READ SHALL NOT affect the hold value already being captured at that edge; the old value SHALL be captured.
REQ-025 cmd_valid asserted outside IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-026 While nrst=0, the FSM SHALL be in IDLE, R0-R6 SHALL equal RST_VAL, the hold register and mem_wdata SHALL be 0, mem_we and done SHALL be 0, and cmd_ready SHALL be 1.
REQ-027 Reset asserted in READ or WRITE SHALL abort the move with no register or memory write and no done pulse.

Configuration
REQ-028 With macro MOV_FLAGS_EN defined, the block SHALL add output zflag (1 bit), reset 0, updated at each WRITE edge to (hold value == 0), and holding its value otherwise.
REQ-029 Without MOV_FLAGS_EN, the zflag port and its logic SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef, the selector constants SEL_R0..SEL_R6 and SEL_MEM (=7), and the default width DW.
REQ-031 The 8:1 source selector SHALL be a separate combinational sub-module named src_select; all state SHALL remain in mov_reg_bank.

Verification
REQ-032 Reset then idle: after nrst release, R0-R6=00, cmd_ready=1, done=0, mem_we=0.
REQ-033 ld R2=8'h5A, then cmd src=2 dst=5: R5=5A at the 3rd edge after acceptance, and done pulses for exactly 1 cycle.
REQ-034 MEMCEE=8'hC3, cmd src=7 dst=0: R0=C3; cmd src=4 dst=7 with R4=8'h11: mem_we=1 and mem_wdata=11 for one cycle, and R0-R6 are unchanged.
REQ-035 During WRITE of a move to dst=3 with value 8'h22, ld_sel=3 and ld_data=8'hFF at the same edge: R3=22; with ld_sel=1 instead: R1=FF and R3=22.
REQ-036 Back-to-back: cmd_valid held high with two commands: the second is accepted in the done cycle, and cmd_valid raised during READ is ignored.
REQ-037 nrst pulsed in READ: no write occurs, done=0, all registers=RST_VAL; with MOV_FLAGS_EN defined, a move of 8'h00 sets zflag=1.
